fetch_redirect_ctrl: RTL and testbench

//  Sequences instruction-fetch redirection for the 5-stage MIPS pipeline.

---
 rtl/fetch_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl - sequences fetch redirection (interrupt/exception vectoring, ERET drain) and owns EPC/cause/EXL.
// Optional perf counters are enabled with `define FETCH_REDIRECT_PERF_EN.
module fetch_redirect_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_stall,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        int_req,
  input  logic        int_en,
  input  logic        eret_req,
  output logic        goto_handler,
  output logic        eret,
  output logic        freeze,
  output logic        flush,
  output logic [31:0] epc,
  output logic [4:0]  cause_code,
  output logic        exl,
  output logic        busy
`ifdef FETCH_REDIRECT_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_evt_cnt
`endif
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_VECTOR,
    S_ERET_DRAIN,
    S_ERET_ISSUE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   epc_q;
  logic [4:0]    cause_q;
  logic          exl_q;
  logic          goto_q;
  logic          eret_q;
  logic          flush_q;
  logic          busy_q;

  logic          take_int;
  logic          take_evt;
  logic          enter_vec;
  logic [31:0]   epc_d;

  assign take_int  = int_req & int_en & ~exl_q;
  assign take_evt  = take_int | exc_req;
  assign enter_vec = take_evt & ((state_q == S_RUN) | (state_q == S_ERET_DRAIN));
  // A delay-slot instruction restarts at its branch so the branch re-executes.
  assign epc_d     = m_bd ? (m_pc - 32'd4) : m_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      epc_q   <= 32'd0;
      cause_q <= 5'd0;
      exl_q   <= 1'b0;
      goto_q  <= 1'b0;
      eret_q  <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      goto_q  <= 1'b0;
      eret_q  <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      case (state_q)
        S_RUN, S_ERET_DRAIN: begin
          if (take_evt) begin
            state_q <= S_VECTOR;
            cause_q <= take_int ? 5'd0 : exc_code;
            if (!exl_q) epc_q <= epc_d;
            exl_q   <= 1'b1;
            goto_q  <= 1'b1;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (state_q == S_RUN) begin
            if (eret_req) begin
              state_q <= S_ERET_DRAIN;
              cnt_q   <= DRAIN_LOAD;
              busy_q  <= 1'b1;
            end
          end else if (cnt_q == '0) begin
            state_q <= S_ERET_ISSUE;
            eret_q  <= 1'b1;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q - CW'(1);
            busy_q <= 1'b1;
          end
        end
        S_VECTOR: state_q <= S_RUN;
        S_ERET_ISSUE: begin
          state_q <= S_RUN;
          exl_q   <= 1'b0;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign goto_handler = goto_q;
  assign eret         = eret_q;
  assign flush        = flush_q;
  assign busy         = busy_q;
  assign epc          = epc_q;
  assign cause_code   = cause_q;
  assign exl          = exl_q;
  assign freeze       = ((state_q == S_RUN) & hazard_stall) | (state_q == S_ERET_DRAIN);

`ifdef FETCH_REDIRECT_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] evt_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      evt_cnt_q   <= 32'd0;
    end else begin
      if (freeze)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (enter_vec) evt_cnt_q   <= evt_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_evt_cnt   = evt_cnt_q;
`else
  logic unused_enter_vec;
  assign unused_enter_vec = enter_vec;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl - directed vector table plus randomized run against a behavioural model.
module tb_fetch_redirect_ctrl;
  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset, hazard_stall, exc_req, m_bd, int_req, int_en, eret_req;
  logic [4:0]  exc_code;
  logic [31:0] m_pc;
  logic        goto_handler, eret, freeze, flush, exl, busy;
  logic [31:0] epc;
  logic [4:0]  cause_code;
`ifdef FETCH_REDIRECT_PERF_EN
  logic [31:0] perf_stall_cnt, perf_evt_cnt;
`endif

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .exc_req(exc_req),
    .exc_code(exc_code), .m_pc(m_pc), .m_bd(m_bd), .int_req(int_req),
    .int_en(int_en), .eret_req(eret_req), .goto_handler(goto_handler),
    .eret(eret), .freeze(freeze), .flush(flush), .epc(epc),
    .cause_code(cause_code), .exl(exl), .busy(busy)
`ifdef FETCH_REDIRECT_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_evt_cnt(perf_evt_cnt)
`endif
  );

  typedef struct {
    int rst; int hs; int exc; int code; logic [31:0] pc; int bd; int irq; int ie; int er;
    int g; int e; int f; int fl; int b; logic [31:0] xepc; int cause; int xexl;
  } vec_t;

  vec_t tbl[33];
  int checks = 0;
  int errors = 0;

  // Behavioural model: a pending redirect, remaining freeze cycles of an ERET, or an ERET being issued.
  bit          m_vec, m_issue, m_exl;
  int          m_drain;
  logic [31:0] m_epc;
  logic [4:0]  m_cause;
  logic [31:0] m_stalls, m_evts;

  function automatic bit mdl_busy();
    return m_vec | m_issue | (m_drain > 0);
  endfunction

  function automatic bit mdl_freeze();
    return (m_drain > 0) | (!mdl_busy() & hazard_stall);
  endfunction

  task automatic model_step();
    bit tint, evt, idle;
    if (reset) begin
      m_vec = 0; m_issue = 0; m_exl = 0; m_drain = 0;
      m_epc = 0; m_cause = 0; m_stalls = 0; m_evts = 0;
    end else begin
      tint = int_req & int_en & ~m_exl;
      evt  = tint | exc_req;
      idle = !mdl_busy();
      if (mdl_freeze()) m_stalls = m_stalls + 1;
      if ((idle || m_drain > 0) && evt) begin
        m_cause = tint ? 5'd0 : exc_code;
        if (!m_exl) m_epc = m_bd ? m_pc - 32'd4 : m_pc;
        m_exl = 1; m_vec = 1; m_drain = 0; m_issue = 0;
        m_evts = m_evts + 1;
      end else if (m_vec) m_vec = 0;
      else if (m_issue) begin m_issue = 0; m_exl = 0; end
      else if (m_drain == 1) begin m_drain = 0; m_issue = 1; end
      else if (m_drain > 1) m_drain = m_drain - 1;
      else if (eret_req) m_drain = DRAIN;
    end
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(string tag, int g, int e, int f, int fl, int b,
                            logic [31:0] xepc, int cause, int xexl);
    check({tag, " goto_handler"}, 32'(goto_handler), 32'(g));
    check({tag, " eret"},         32'(eret),         32'(e));
    check({tag, " freeze"},       32'(freeze),       32'(f));
    check({tag, " flush"},        32'(flush),        32'(fl));
    check({tag, " busy"},         32'(busy),         32'(b));
    check({tag, " epc"},          epc,               xepc);
    check({tag, " cause_code"},   32'(cause_code),   32'(cause));
    check({tag, " exl"},          32'(exl),          32'(xexl));
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    //            rst hs exc code pc          bd irq ie er   g e f fl b  epc           cause exl
    tbl[0]  = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,0,0,0, 32'h0,        0,  0};
    tbl[1]  = '{0, 0, 1, 4,  32'h3010,    0, 0, 0, 0,   0,0,0,0,0, 32'h0,        0,  0};
    tbl[2]  = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   1,0,0,1,1, 32'h3010,     4,  1};
    tbl[3]  = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,0,0,0, 32'h3010,     4,  1};
    tbl[4]  = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 1,   0,0,0,0,0, 32'h3010,     4,  1};
    tbl[5]  = '{0, 1, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,1, 32'h3010,     4,  1};
    tbl[6]  = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,1, 32'h3010,     4,  1};
    tbl[7]  = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 1,   0,0,1,0,1, 32'h3010,     4,  1};
    tbl[8]  = '{0, 1, 0, 0,  32'h0,       0, 0, 0, 0,   0,1,0,1,1, 32'h3010,     4,  1};
    tbl[9]  = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,0,0,0, 32'h3010,     4,  0};
    tbl[10] = '{0, 0, 1, 7,  32'h3024,    1, 0, 0, 0,   0,0,0,0,0, 32'h3010,     4,  0};
    tbl[11] = '{0, 0, 1, 10, 32'h5000,    0, 0, 0, 0,   1,0,0,1,1, 32'h3020,     7,  1};
    tbl[12] = '{0, 0, 1, 10, 32'h4444,    0, 0, 0, 0,   0,0,0,0,0, 32'h3020,     7,  1};
    tbl[13] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   1,0,0,1,1, 32'h3020,     10, 1};
    tbl[14] = '{0, 0, 0, 0,  32'h0,       0, 1, 1, 0,   0,0,0,0,0, 32'h3020,     10, 1};
    tbl[15] = '{0, 0, 0, 0,  32'h0,       0, 1, 1, 1,   0,0,0,0,0, 32'h3020,     10, 1};
    tbl[16] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,1, 32'h3020,     10, 1};
    tbl[17] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,1, 32'h3020,     10, 1};
    tbl[18] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,1, 32'h3020,     10, 1};
    tbl[19] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,1,0,1,1, 32'h3020,     10, 1};
    tbl[20] = '{0, 0, 1, 12, 32'h6000,    0, 1, 1, 0,   0,0,0,0,0, 32'h3020,     10, 0};
    tbl[21] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   1,0,0,1,1, 32'h6000,     0,  1};
    tbl[22] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 1,   0,0,0,0,0, 32'h6000,     0,  1};
    tbl[23] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,1, 32'h6000,     0,  1};
    tbl[24] = '{0, 0, 1, 3,  32'h7000,    0, 0, 0, 0,   0,0,1,0,1, 32'h6000,     0,  1};
    tbl[25] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   1,0,0,1,1, 32'h6000,     3,  1};
    tbl[26] = '{0, 1, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,0, 32'h6000,     3,  1};
    tbl[27] = '{0, 1, 0, 0,  32'h0,       0, 0, 0, 1,   0,0,1,0,0, 32'h6000,     3,  1};
    tbl[28] = '{1, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,1, 32'h6000,     3,  1};
    tbl[29] = '{0, 1, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,1,0,0, 32'h0,        0,  0};
    tbl[30] = '{0, 0, 1, 1,  32'h2,       1, 0, 0, 0,   0,0,0,0,0, 32'h0,        0,  0};
    tbl[31] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   1,0,0,1,1, 32'hFFFFFFFE, 1,  1};
    tbl[32] = '{0, 0, 0, 0,  32'h0,       0, 0, 0, 0,   0,0,0,0,0, 32'hFFFFFFFE, 1,  1};

    reset = 1; hazard_stall = 0; exc_req = 0; exc_code = 0; m_pc = 0; m_bd = 0;
    int_req = 0; int_en = 0; eret_req = 0;
    repeat (2) @(posedge clk);
    model_step();
    #1;

    for (int i = 0; i < 33; i++) begin
      reset = tbl[i].rst[0]; hazard_stall = tbl[i].hs[0]; exc_req = tbl[i].exc[0];
      exc_code = tbl[i].code[4:0]; m_pc = tbl[i].pc; m_bd = tbl[i].bd[0];
      int_req = tbl[i].irq[0]; int_en = tbl[i].ie[0]; eret_req = tbl[i].er[0];
      @(negedge clk);
      check_outs($sformatf("row%0d", i), tbl[i].g, tbl[i].e, tbl[i].f, tbl[i].fl,
                 tbl[i].b, tbl[i].xepc, tbl[i].cause, tbl[i].xexl);
      finish_cycle();
    end

    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(63) == 0);
      hazard_stall = ($urandom_range(2) == 0);
      exc_req      = ($urandom_range(7) == 0);
      exc_code     = 5'($urandom);
      m_pc         = $urandom;
      m_bd         = $urandom_range(1) == 1;
      int_req      = ($urandom_range(5) == 0);
      int_en       = $urandom_range(1) == 1;
      eret_req     = ($urandom_range(4) == 0);
      @(negedge clk);
      check_outs($sformatf("rnd%0d", n), int'(m_vec), int'(m_issue), int'(mdl_freeze()),
                 int'(m_vec | m_issue), int'(mdl_busy()), m_epc, int'(m_cause), int'(m_exl));
`ifdef FETCH_REDIRECT_PERF_EN
      check($sformatf("rnd%0d perf_stall_cnt", n), perf_stall_cnt, m_stalls);
      check($sformatf("rnd%0d perf_evt_cnt", n), perf_evt_cnt, m_evts);
`endif
      finish_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
